rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter sharing one resource: a single downstream port, such as a shared bus or unit.
- Uses rotated first-one priority selection: the first set request at or after a rotating pointer wins.
- Holds each grant until the owner signals done or drops its request, then rotates priority.
- Sits between four client blocks and the shared resource. All outputs are registered.

Parameters:
- HOLD_MAX, 8, maximum grant duration in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 1-255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request lines. req[i] high = requester i wants the resource.
- done  input  4  done[i] high for one cycle = owner i releases the resource. Ignored when i is not the owner.
- gnt  output  4  one-hot grant. All zero when no owner.
- gnt_idx  output  2  index of the current owner. Holds the last owner when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse on forced release. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, state=IDLE, hold counter=0.
- Reset mid-grant drops the grant immediately. There is no completion handshake.
- Internal pointer ptr[1:0] holds the highest-priority index.
- Priority order: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Selection is combinational from req and ptr. Grant outputs are registered.
- State IDLE:
  - All grant outputs are low.
  - If req != 0, the winner is the first set bit in rotated order.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_idx=winner, gnt_valid=1.
  - Latency is 1 cycle from req assertion to gnt.
  - If req == 0, remain in IDLE.
- State GRANT, owner o:
  - Release condition: done[o]=1 or req[o]=0, sampled at the edge.
  - On release, ptr <= o+1 mod 4.
  - If any request other than o is pending, grant passes to the next winner on the same edge. The winner is searched from o+1, so there is no idle bubble between owners.
  - If no other request is pending, go to IDLE with gnt=0 and gnt_valid=0.
  - An owner holding req high after done with no competitors is re-granted on that edge: the search from o+1 wraps to o.
  - Without release, the grant is held unchanged regardless of other requests.
- done bits of non-owners are ignored. Multiple done bits are legal; only done[o] matters.
- gnt is always one-hot or zero. gnt_valid equals the OR of gnt.
- Fairness: a continuously requesting client waits at most 3 grant tenures.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on every new grant, including back-to-back hand-off, and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 without release, a forced release occurs on the next edge, with the same hand-off rules as a normal release.
  - preempt pulses high for the one cycle after the forced release edge.
  - If the owner releases normally on the same edge the count expires, it is a normal release and no preempt is issued.
- When undefined:
  - No counter and no preempt port.
  - A grant is held indefinitely until release.

Test Plan:
- Reset with req=4'b1111 held: gnt=0 and gnt_valid=0 during rst. At the first edge after rst falls, gnt=4'b0001 and gnt_idx=0.
- req=4'b1111 constant, owner pulses done after 2 cycles each tenure: grant sequence 0001 -> 0010 -> 0100 -> 1000 -> 0001. There is no cycle with gnt_valid=0 between tenures.
- Single requester: req=4'b0100 and done[2] pulsed every 3 cycles → gnt stays 0100, with gnt_valid high throughout.
- Owner 1 drops req with no done while req=4'b1001 pending (ptr now 2): next gnt=1000, then after its release gnt=0001.
- Mid-grant async reset: owner 3 active and rst pulsed between edges → gnt=0 immediately. After reset, req=4'b1010 gives gnt=0010 (ptr reset to 0).
- ARB_TIMEOUT_EN, HOLD_MAX=4: req=4'b0011 held with no done → gnt=0001 for 4 cycles, then gnt=0010 with preempt=1 for one cycle. Rotation then continues every 4 cycles.

Source files
------------

// File: rtl/rr_arbiter4.sv
// ============================================================================
// rr_arbiter4 : four-requester round-robin arbiter, registered grant outputs.
// Optional ARB_TIMEOUT_EN macro adds a hold-time limit and a preempt pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic       preempt
`endif
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_arbiter4: HOLD_MAX must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_idx_nxt;
    logic       w_valid_nxt;

    logic [1:0] w_base;
    logic       w_found;
    logic [1:0] w_win;
    logic       w_release;
    logic       w_rotate;

    // First set request at or after base, wrapping modulo 4.
    function automatic logic [2:0] pick_first(input logic [3:0] r, input logic [1:0] base);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r[base + 2'(k)]) begin
                found = 1'b1;
                idx   = base + 2'(k);
            end
        end
        return {found, idx};
    endfunction

    // While granted, the search starts just past the owner so hand-off has no bubble.
    assign w_base            = (r_state == GRANT) ? (gnt_idx + 2'd1) : r_ptr;
    assign {w_found, w_win}  = pick_first(req, w_base);
    assign w_release         = done[gnt_idx] | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       w_preempt_nxt;
    logic       w_expire;

    assign w_expire = (r_cnt == 8'(HOLD_MAX - 1));
    assign w_rotate = w_release | w_expire;
`else
    assign w_rotate = w_release;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = gnt;
        w_idx_nxt   = gnt_idx;
        w_valid_nxt = gnt_valid;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_preempt_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (w_rotate) begin
                    w_ptr_nxt = gnt_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    w_preempt_nxt = w_expire & ~w_release;
                    w_cnt_nxt     = 8'd0;
`endif
                    if (w_found) begin
                        w_gnt_nxt   = 4'b0001 << w_win;
                        w_idx_nxt   = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt = r_cnt + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            gnt       <= w_gnt_nxt;
            gnt_idx   <= w_idx_nxt;
            gnt_valid <= w_valid_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            preempt <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            preempt <= w_preempt_nxt;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ============================================================================
// tb_rr_arbiter4 : scoreboard-driven self-checking bench for rr_arbiter4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter4;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt_obs;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .preempt   (preempt_obs)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    assign preempt_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_cnt;

    task automatic model_reset();
        m_valid = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        bit   rel, hit, found;
        int   base, w;
        e     = '0;
        found = 0;
        w     = 0;
        base  = m_valid ? (m_owner + 1) % 4 : m_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && r[(base + k) % 4]) begin
                found = 1;
                w     = (base + k) % 4;
            end
        end
        if (!m_valid) begin
            if (found) begin
                m_valid = 1;
                m_owner = w;
                m_cnt   = 0;
            end
        end else begin
            rel = d[m_owner] || !r[m_owner];
            hit = TIMEOUT && (m_cnt == HOLD - 1);
            if (rel || hit) begin
                m_ptr = (m_owner + 1) % 4;
                e.p   = hit && !rel;
                if (found) begin
                    m_owner = w;
                    m_cnt   = 0;
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        e.g = m_valid ? 4'(1 << m_owner) : 4'b0000;
        e.i = 2'(m_owner);
        e.v = m_valid;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, then score the registered result after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, preempt_obs} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: got gnt=%b idx=%0d valid=%b pre=%b, expected gnt=%b idx=%0d valid=%b pre=%b",
                     $time, gnt, gnt_idx, gnt_valid, preempt_obs, e.g, e.i, e.v, e.p);
        end
        checks++;
        if (gnt_valid !== (|gnt) || $countones(gnt) > 1) begin
            errors++;
            $display("FAIL onehot t=%0t: gnt=%b valid=%b", $time, gnt, gnt_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: gnt=%b valid=%b idx=%0d, expected 0000/0/0", gnt, gnt_valid, gnt_idx);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b1111, 4'b0000);
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b idx=%0d, expected 0001/0", gnt, gnt_idx);
        end
    endtask

    task automatic test_rotation();
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b0000);
            step(4'b1111, 4'(1 << k));
            checks++;
            if (gnt !== 4'(1 << ((k + 1) % 4)) || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_%0d: gnt=%b valid=%b, expected %b/1", k, gnt, gnt_valid, 4'(1 << ((k + 1) % 4)));
            end
        end
    endtask

    task automatic test_single();
        step(4'b0000, 4'b0000);
        step(4'b0100, 4'b0000);
        repeat (3) begin
            step(4'b0100, 4'b0000);
            step(4'b0100, 4'b0000);
            step(4'b0100, 4'b0100);
            checks++;
            if (gnt !== 4'b0100 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_regrant: gnt=%b valid=%b, expected 0100/1", gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_drop();
        step(4'b0000, 4'b0000);
        step(4'b0010, 4'b0000);
        step(4'b1011, 4'b0000);
        step(4'b1001, 4'b0000);
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL drop_handoff: gnt=%b idx=%0d, expected 1000/3", gnt, gnt_idx);
        end
        step(4'b1001, 4'b1000);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL drop_wrap: gnt=%b, expected 0001", gnt);
        end
    endtask

    task automatic test_async_reset();
        step(4'b1000, 4'b0000);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL async_setup: gnt=%b, expected 1000", gnt);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_clear: gnt=%b valid=%b idx=%0d, expected 0000/0/0", gnt, gnt_valid, gnt_idx);
        end
        #1 rst = 1'b0;
        model_reset();
        step(4'b1010, 4'b0000);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL async_ptr_reset: gnt=%b, expected 0010", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r, d;
        for (int n = 0; n < 300; n++) begin
            r = 4'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(r, d);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int n = 1; n <= 13; n++) begin
            step(4'b0011, 4'b0000);
            if (preempt_obs === 1'b1) pulses++;
            if (n == 5) begin
                checks++;
                if (gnt !== 4'b0010 || preempt_obs !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_first: gnt=%b pre=%b, expected 0010/1", gnt, preempt_obs);
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, expected 3", pulses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_single();
        test_drop();
        test_async_reset();
        test_random();
        if (TIMEOUT) test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
